// File: rtl/sys_bridge.sv
// sys_bridge: CPU-side initiator for the peripheral window (DEV0, DEV1, local IRQ register).
// Define BRIDGE_IRQ_SYNC_EN to pass the IRQ inputs through two-flop synchronizers.
module sys_bridge #(
    parameter logic [31:0] DEV0_BASE   = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE   = 32'h0000_7F10,
    parameter logic [31:0] LOCAL_BASE  = 32'h0000_7F20,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev0_we,
    output logic        dev1_we,
    input  logic [31:0] dev0_rdata,
    input  logic [31:0] dev1_rdata,
    input  logic        dev0_irq,
    input  logic        dev1_irq,
    input  logic        ext_irq,
    output logic [5:0]  hwint
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state;
    logic [1:0]  tgt;
    logic        we_q, first, pending, ext_prev, clr, pending_nxt;
    logic [3:0]  cnt;
    logic        d0_s, d1_s, ext_s, hit0, hit1, hitl, bad;
    logic [31:0] rd_sel;

`ifdef BRIDGE_IRQ_SYNC_EN
    logic [1:0] d0_ff, d1_ff, ext_ff;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            d0_ff  <= '0;
            d1_ff  <= '0;
            ext_ff <= '0;
        end else begin
            d0_ff  <= {d0_ff[0], dev0_irq};
            d1_ff  <= {d1_ff[0], dev1_irq};
            ext_ff <= {ext_ff[0], ext_irq};
        end
    assign d0_s  = d0_ff[1];
    assign d1_s  = d1_ff[1];
    assign ext_s = ext_ff[1];
`else
    assign d0_s  = dev0_irq;
    assign d1_s  = dev1_irq;
    assign ext_s = ext_irq;
`endif

    assign hit0 = cpu_addr >= DEV0_BASE && cpu_addr < DEV0_BASE + 32'd12;
    assign hit1 = cpu_addr >= DEV1_BASE && cpu_addr < DEV1_BASE + 32'd12;
    assign hitl = cpu_addr == LOCAL_BASE;
    assign bad  = cpu_addr[1:0] != 2'b00 || !(hit0 || hit1 || hitl);

    assign rd_sel = tgt == 2'd0 ? dev0_rdata : tgt == 2'd1 ? dev1_rdata : {31'b0, pending};
    // write-1-to-clear lands on the first ACCESS cycle; a new edge in the same cycle wins
    assign clr         = state == ACCESS && first && tgt == 2'd2 && we_q && dev_wdata[0];
    assign pending_nxt = (pending & ~clr) | (ext_s & ~ext_prev);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            tgt       <= '0;
            we_q      <= 1'b0;
            first     <= 1'b0;
            cnt       <= '0;
            pending   <= 1'b0;
            ext_prev  <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            dev0_we   <= 1'b0;
            dev1_we   <= 1'b0;
            hwint     <= '0;
        end else begin
            dev0_we   <= 1'b0;
            dev1_we   <= 1'b0;
            cpu_ready <= 1'b0;
            first     <= 1'b0;
            pending   <= pending_nxt;
            ext_prev  <= ext_s;
            hwint     <= {3'b0, pending_nxt, d1_s, d0_s};
            case (state)
                IDLE: if (cpu_req) begin
                    dev_addr  <= cpu_addr;
                    dev_wdata <= cpu_wdata;
                    we_q      <= cpu_we;
                    tgt       <= hit0 ? 2'd0 : hit1 ? 2'd1 : 2'd2;
                    if (bad) begin
                        state     <= RESP;
                        cpu_ready <= 1'b1;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= '0;
                    end else begin
                        state   <= ACCESS;
                        cnt     <= 4'(WAIT_CYCLES);
                        first   <= 1'b1;
                        dev0_we <= cpu_we && hit0;
                        dev1_we <= cpu_we && hit1;
                    end
                end
                ACCESS: if (cnt == 4'd0) begin
                    cpu_rdata <= we_q ? 32'd0 : rd_sel;
                    cpu_err   <= 1'b0;
                    cpu_ready <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state   <= IDLE;
                    cpu_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_sys_bridge.sv
// tb_sys_bridge: random and directed accesses checked against a transaction-level model of the bridge.
module tb_sys_bridge;
    localparam int W = 1;
`ifdef BRIDGE_IRQ_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    logic        clk = 0, reset = 0, cpu_req = 0, cpu_we = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, dev0_val = 0, dev1_val = 0;
    logic        dev0_irq = 0, dev1_irq = 0, ext_irq = 0;
    logic        cpu_ready, cpu_err, dev0_we, dev1_we;
    logic [31:0] cpu_rdata, dev_addr, dev_wdata;
    logic [5:0]  hwint;
    int          total = 0, bad = 0;
    bit          pend = 0;

    sys_bridge #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev0_we(dev0_we), .dev1_we(dev1_we),
        .dev0_rdata(dev0_val), .dev1_rdata(dev1_val), .dev0_irq(dev0_irq), .dev1_irq(dev1_irq),
        .ext_irq(ext_irq), .hwint(hwint)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // full 32-bit address arithmetic, word alignment required
    function automatic int target(input logic [31:0] a);
        if (a[1:0] != 0) return -1;
        if (a >= 32'h7F00 && a < 32'h7F0C) return 0;
        if (a >= 32'h7F10 && a < 32'h7F1C) return 1;
        if (a == 32'h7F20) return 2;
        return -1;
    endfunction

    task automatic access(input logic [31:0] a, input bit we, input logic [31:0] d);
        int t = target(a), n = 0, s0 = 0, s1 = 0;
        bit got = 0;
        logic [31:0] exp_rd;
        exp_rd = (t < 0 || we) ? 32'd0 : t == 0 ? dev0_val : t == 1 ? dev1_val : {31'b0, pend};
        @(negedge clk);
        cpu_req = 1; cpu_addr = a; cpu_we = we; cpu_wdata = d;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (dev0_we) begin s0++; chk("strobe_addr", dev_addr, a); chk("strobe_data", dev_wdata, d); end
            if (dev1_we) begin s1++; chk("strobe_addr", dev_addr, a); chk("strobe_data", dev_wdata, d); end
            if (cpu_ready) begin got = 1; cpu_req = 0; end
        end
        chk("latency", n, t < 0 ? 1 : W + 2);
        chk("rdata", cpu_rdata, exp_rd);
        chk("err", cpu_err, t < 0);
        chk("dev0_we_cnt", s0, (t == 0 && we) ? 1 : 0);
        chk("dev1_we_cnt", s1, (t == 1 && we) ? 1 : 0);
        chk("dev_addr", dev_addr, a);
        if (t == 2 && we && d[0]) pend = 0;
        @(posedge clk); #1;
        chk("ready_pulse", cpu_ready, 0);
        chk("hwint", hwint, {3'b0, pend, dev1_irq, dev0_irq});
    endtask

    task automatic irq_lat(input int b, input bit v);
        for (int k = 1; k <= L; k++) begin
            @(posedge clk); #1;
            chk("irq_lat", hwint[b], k >= L ? v : ~v);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", {cpu_ready, cpu_err, dev0_we, dev1_we, hwint}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_addr", dev_addr, 0);
        chk("rst_wdata", dev_wdata, 0);
        @(negedge clk); reset = 1;

        dev0_val = 32'h10;
        access(32'h7F04, 0, 0);
        access(32'h7F10, 1, 32'h9);
        access(32'h7F0C, 0, 0);
        access(32'h7F05, 0, 0);

        @(negedge clk); ext_irq = 1;
        for (int k = 1; k <= L + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) ext_irq = 0;
            chk("ext_lat", hwint[2], k >= L);
        end
        pend = 1;
        access(32'h7F20, 0, 0);
        access(32'h7F20, 1, 32'h1);

        // edge detected on the same clock that the clear is applied
        for (int j = -1; j <= 3; j++) begin
            @(negedge clk);
            ext_irq = (j == 2 - L);
            if (j == 0) begin cpu_req = 1; cpu_addr = 32'h7F20; cpu_we = 1; cpu_wdata = 1; end
            if (j == 3) cpu_req = 0;
        end
        @(posedge clk); #1;
        chk("set_wins", hwint[2], 1);
        pend = 1;
        access(32'h7F20, 0, 0);
        access(32'h7F20, 1, 32'hFFFF_FFFF);

        @(negedge clk); dev0_irq = 1;
        irq_lat(0, 1);
        @(negedge clk); dev0_irq = 0;
        irq_lat(0, 0);
        @(negedge clk); dev1_irq = 1;
        irq_lat(1, 1);
        @(negedge clk); dev1_irq = 0;
        irq_lat(1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: a = 32'h7F00 + 4 * $urandom_range(0, 2);
                1: a = 32'h7F10 + 4 * $urandom_range(0, 2);
                2: a = 32'h7F20;
                3: a = 32'h7F00 + {$urandom_range(0, 7), 2'b01};
                4: a = 32'h7F0C + 32'h10 * $urandom_range(0, 1);
                default: a = $urandom;
            endcase
            dev0_val = $urandom;
            dev1_val = $urandom;
            access(a, 1'($urandom_range(0, 1)), $urandom);
        end

        @(negedge clk);
        cpu_req = 1; cpu_addr = 32'h7F00; cpu_we = 1; cpu_wdata = 32'h55;
        @(posedge clk); #1;
        chk("rst_pre_we", dev0_we, 1);
        reset = 0;
        #1;
        chk("rst_mid_ctl", {cpu_ready, cpu_err, dev0_we, dev1_we, hwint}, 0);
        chk("rst_mid_addr", dev_addr, 0);
        chk("rst_mid_wdata", dev_wdata, 0);
        chk("rst_mid_rdata", cpu_rdata, 0);
        cpu_req = 0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold", {cpu_ready, dev0_we, dev1_we}, 0);
        end
        @(negedge clk); reset = 1;
        pend = 0;
        dev1_val = 32'hCAFE_0001;
        access(32'h7F18, 0, 0);
        access(32'h7F08, 1, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_bridge.md
Name: sys_bridge

Overview:
- CPU-side bus initiator for the memory-mapped peripheral window.
- Accepts one load/store at a time from the CPU over a req/ready handshake.
- Decodes the address to timer slot DEV0, timer slot DEV1 or a local IRQ register.
- Drives the device address/write-enable/data lines, inserts configurable wait states, registers the read data and returns it.
- Collects device IRQ lines into a registered hwint vector for CP0.

Parameters:
- DEV0_BASE, 32'h0000_7F00, base of device 0 (three word registers, 12 bytes).
- DEV1_BASE, 32'h0000_7F10, base of device 1 (three word registers, 12 bytes).
- LOCAL_BASE, 32'h0000_7F20, bridge-local IRQ pending/ack register (one word).
- WAIT_CYCLES, 1, extra ACCESS cycles before read data is captured (0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held by CPU until cpu_ready
- cpu_addr  in  32  byte address
- cpu_we  in  1  1 = store, 0 = load
- cpu_wdata  in  32  store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ready
- cpu_err  out  1  unmapped/misaligned access, valid while cpu_ready
- dev_addr  out  32  address to devices (latched cpu_addr)
- dev_wdata  out  32  write data to devices (latched cpu_wdata)
- dev0_we  out  1  write strobe, device 0
- dev1_we  out  1  write strobe, device 1
- dev0_rdata  in  32  device 0 read data (combinational on dev_addr)
- dev1_rdata  in  32  device 1 read data
- dev0_irq  in  1  device 0 interrupt, level
- dev1_irq  in  1  device 1 interrupt, level
- ext_irq  in  1  external interrupt, pulse
- hwint  out  6  registered interrupt vector to CP0

Behaviour:
- Reset (async, active-low): state IDLE. cpu_ready=0, cpu_err=0, cpu_rdata=0. dev0_we=dev1_we=0. dev_addr=0, dev_wdata=0, hwint=0, pending=0, wait counter=0. Reset mid-access aborts the access; no strobe is issued after reset asserts.
- Decode (in IDLE, on cpu_req):
  - DEV0 hit if DEV0_BASE <= addr < DEV0_BASE+12. DEV1 hit likewise for DEV1_BASE.
  - LOCAL hit if addr == LOCAL_BASE.
  - Any other address, or addr[1:0] != 0, is an error.
- State IDLE:
  - cpu_req=1 latches addr/we/wdata and the decode result.
  - Error target: go to RESP with err=1.
  - Otherwise: go to ACCESS, wait counter = WAIT_CYCLES.
- State ACCESS:
  - dev_addr and dev_wdata hold the latched values.
  - On the first ACCESS cycle only, the write strobe of the hit device is high if we=1. Exactly one cycle regardless of WAIT_CYCLES.
  - Counter decrements each cycle. When it is 0, capture read data: hit device's rdata for loads, pending word for LOCAL loads, 0 for stores. Then go to RESP.
  - A LOCAL store clears every pending bit whose cpu_wdata bit is 1 (write-1-to-clear), applied on the first ACCESS cycle.
- State RESP: cpu_ready=1 for exactly one cycle with rdata/err. Next state IDLE. cpu_err=0 for mapped accesses; rdata=0 on error.
- Latency: mapped access asserts cpu_ready WAIT_CYCLES+2 cycles after the cycle cpu_req is first sampled in IDLE. An error access asserts it 1 cycle after.
- Back-to-back: a held cpu_req is resampled in the IDLE cycle following RESP. No request is accepted outside IDLE.
- Interrupts:
  - pending[0] is set on a rising edge of ext_irq (previous-sample register); set wins over a simultaneous clear.
  - LOCAL read word = {31'b0, pending[0]}.
  - hwint = {3'b0, pending[0], dev1_irq, dev0_irq}, registered; 1 cycle latency from input to output.

Optional Feature:
- BRIDGE_IRQ_SYNC_EN defined: dev0_irq, dev1_irq and ext_irq pass through a two-flop synchronizer before edge detection/registering. hwint latency becomes 3 cycles.
- Undefined: inputs are used directly; latency is 1 cycle.

Test Plan:
- WAIT_CYCLES=1, load 0x7F04 with dev0_rdata=32'h0000_0010 -> cpu_ready high exactly 3 cycles after req sampled, cpu_rdata=0x10, err=0, no we pulse.
- Store 0x7F10 data 0x9 -> dev1_we high exactly one cycle, dev_addr=0x7F10, dev_wdata=0x9, dev0_we stays 0; cpu_ready once.
- Load 0x7F0C and load 0x7F05 -> cpu_ready next cycle, err=1, rdata=0, no strobes.
- One-cycle ext_irq pulse -> hwint[2]=1 after 1 cycle (3 with BRIDGE_IRQ_SYNC_EN). LOCAL load returns 1. Store 0x1 to 0x7F20 -> hwint[2]=0. Pulse coincident with clear -> bit stays 1.
- dev0_irq held high then low -> hwint[0] follows with the stated latency.
- Assert reset during ACCESS of a store with WAIT_CYCLES=3 -> all outputs 0 immediately, state IDLE. A new request after release completes normally.
